// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply-divide unit: iterative radix-2 MULT/MULTU/DIV/DIVU plus
// MTHI/MTLO writes. One step per RUN cycle, sign fix-up in FINISH, then
// HI/LO are written and done pulses for one cycle.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    // Multiplicand for multiply, divisor for divide (always a magnitude).
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // Upper WIDTH+1 bits: partial product / partial remainder.
    // Lower WIDTH bits: multiplier bits / dividend bits becoming the quotient.
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH:0]   step_acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign op_signed = ~op[0];
    assign a_mag     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_mag     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // One radix-2 step: shift-add multiply or restoring shift-subtract divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
        div_ge   = ~div_diff[WIDTH+1];
        if (is_div_q) begin
            step_acc = {(div_ge ? div_diff[WIDTH:0] : rem_sh),
                        acc_q[WIDTH-2:0], div_ge};
        end else begin
            step_acc = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign correction applied to the finished magnitude result. With a zero
    // divisor the restoring divider yields an all-ones quotient and the
    // dividend magnitude as remainder, so re-signing the remainder restores
    // the original src_a.
    always_comb begin
        prod = (a_neg_q ^ b_neg_q) ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        quo  = (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (is_div_q && (opnd_q == '0)) begin
            quo = '1;
        end
    end

    // Next-state and datapath control for the IDLE/RUN/FINISH sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    unique case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d = op[1];
                            a_neg_d  = op_signed & src_a[WIDTH-1];
                            b_neg_d  = op_signed & src_b[WIDTH-1];
                            opnd_d   = op[1] ? b_mag : a_mag;
                            acc_d    = {{(WIDTH+1){1'b0}}, (op[1] ? a_mag : b_mag)};
                            cnt_d    = CW'(WIDTH-1);
                            state_d  = RUN;
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    if (cnt_q == '0) begin
                        state_d = FINISH;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d  = rem;
                        lo_d  = quo;
                        dbz_d = (opnd_q == '0);
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and HI/LO registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit at WIDTH=32.
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         flush;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Issue a mul/div in cycle 0 (called at a negedge) and follow it to done.
    // poke > 0 raises start with another MULTU in that cycle while busy.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input logic exp_dbz, input int poke);
        int  n     = 0;
        int  bcnt  = 0;
        bit  got   = 0;
        start = 1'b1; op = o; src_a = a; src_b = b;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            start = (n == poke);
            if (n == poke) begin
                op = 3'b001; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
            end
            if (busy) bcnt++;
            if (done) got = 1;
        end
        start = 1'b0;
        check({tag, "_latency"}, n, 34);
        check({tag, "_busy_cycles"}, bcnt, 33);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_dbz"}, div_by_zero, exp_dbz);
        @(negedge clk);
        check({tag, "_done_drop"}, done, 0);
    endtask

    initial begin
        int dcnt;
        logic [W-1:0] old_hi, old_lo;
        reset = 1'b0; start = 1'b0; op = 3'b000; src_a = '0; src_b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);

        // First start right after reset release is accepted on the first edge.
        reset = 1'b1;
        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
        run_op("mult_m3x5", 3'b000, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
        run_op("mult_7xm6", 3'b000, 32'd7, 32'hFFFF_FFFA,
               32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 0);
        run_op("div_m7d2", 3'b010, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("div_7dm2", 3'b010, 32'd7, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("divu_100d0", 3'b011, 32'd100, 32'd0,
               32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 1'b0, 0);
        run_op("divu_100d7", 3'b011, 32'd100, 32'd7,
               32'h0000_0002, 32'h0000_000E, 1'b0, 0);
        // Start during busy must be ignored; original 3*4 result stands.
        run_op("multu_poke", 3'b001, 32'd3, 32'd4,
               32'h0000_0000, 32'h0000_000C, 1'b0, 5);

        // MTLO / MTHI: one-cycle writes, no busy, no done.
        start = 1'b1; op = 3'b101; src_a = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'hCAFE_F00D);
        check("mtlo_hi_keep", hi, 32'h0000_0000);
        check("mtlo_busy", busy, 0);
        check("mtlo_done", done, 0);

        // No-op code is ignored.
        start = 1'b1; op = 3'b110; src_a = 32'h1111_1111;
        @(negedge clk);
        start = 1'b0;
        check("nop_busy", busy, 0);
        check("nop_lo", lo, 32'hCAFE_F00D);

        // Flush together with MTLO in IDLE suppresses the write.
        start = 1'b1; flush = 1'b1; op = 3'b101; src_a = 32'h2222_2222;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_mtlo_lo", lo, 32'hCAFE_F00D);
        check("flush_mtlo_busy", busy, 0);

        // Flush mid-multiply in cycle 10, MTHI in cycle 11.
        old_hi = hi; old_lo = lo;
        start = 1'b1; op = 3'b000; src_a = 32'd9; src_b = 32'd9;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (n == 10);
        end
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_hi", hi, old_hi);
        check("flush_lo", lo, old_lo);
        start = 1'b1; op = 3'b100; src_a = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo_keep", lo, old_lo);
        dcnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("flush_no_done", dcnt, 0);

        // Asynchronous reset during cycle 15 of a DIVU.
        start = 1'b1; op = 3'b011; src_a = 32'd1000; src_b = 32'd3;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_done", done, 0);
        check("midrst_dbz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b1;
        run_op("divu_post_rst", 3'b011, 32'd1000, 32'd3,
               32'h0000_0001, 32'h0000_014D, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
